// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its picker.
package uart_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_START = 2'b01,
        ARB_WAIT  = 2'b10
    } arb_state_e;

    // Ceiling log2 for sizing index and counter fields (clog2(1) == 0).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational rotate-priority picker: first set request after 'last', wrapping.
module uart_rr_pick
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    localparam int unsigned ID_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             valid,
    output logic [ID_W-1:0]  sel
);

    // Scan from the farthest offset down to the nearest so the nearest requester wins.
    always_comb begin
        int unsigned idx;
        valid = 1'b0;
        sel   = '0;
        idx   = 0;
        for (int unsigned k = N_REQ; k >= 1; k--) begin
            idx = (32'(last) + k) % N_REQ;
            if (req[ID_W'(idx)]) begin
                valid = 1'b1;
                sel   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte sources.
// Optional build macro UART_ARB_LOCK_EN adds a per-requester lock input that
// re-grants the last owner ahead of rotation for multi-byte frames.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 64,
    localparam int unsigned ID_W   = clog2(N_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [UART_BYTE_W*N_REQ-1:0] req_data,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]             lock,
`endif
    output logic [N_REQ-1:0]             ack,
    output logic [N_REQ-1:0]             sent,
    output logic [ID_W-1:0]              owner,
    output logic                         arb_busy,
    output logic                         err,
    output logic                         tx_start,
    output logic [UART_BYTE_W-1:0]       tx_data,
    input  logic                         tx_busy,
    input  logic                         tx_done
);

    localparam int unsigned TMO_W = clog2(TIMEOUT) + 1;

    arb_state_e             state_q, state_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [ID_W-1:0]        owner_d;
    logic [UART_BYTE_W-1:0] tx_data_d;
    logic                   tx_start_d;
    logic [N_REQ-1:0]       ack_d, sent_d;
    logic                   err_d;
    logic                   arb_busy_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   busy_q;
    logic                   pick_valid;
    logic [ID_W-1:0]        pick_sel;
    logic                   grant_valid;
    logic [ID_W-1:0]        grant_sel;
`ifdef UART_ARB_LOCK_EN
    logic                   lock_ok_q, lock_ok_d;
    logic                   lock_hit;
`endif

    uart_rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // Grant choice: a live lock on the last owner (after a clean send) pre-empts rotation.
`ifdef UART_ARB_LOCK_EN
    assign lock_hit    = lock_ok_q && lock[last_q] && req[last_q];
    assign grant_valid = pick_valid || lock_hit;
    assign grant_sel   = lock_hit ? last_q : pick_sel;
`else
    assign grant_valid = pick_valid;
    assign grant_sel   = pick_sel;
`endif

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        owner_d    = owner;
        tx_data_d  = tx_data;
        tx_start_d = tx_start;
        ack_d      = '0;
        sent_d     = '0;
        err_d      = 1'b0;
        tmo_d      = tmo_q;
`ifdef UART_ARB_LOCK_EN
        lock_ok_d  = lock_ok_q;
`endif
        unique case (state_q)
            ARB_IDLE: begin
                if (grant_valid) begin
                    tx_data_d        = req_data[UART_BYTE_W*grant_sel +: UART_BYTE_W];
                    owner_d          = grant_sel;
                    ack_d[grant_sel] = 1'b1;
                    tx_start_d       = 1'b1;
                    tmo_d            = '0;
                    state_d          = ARB_START;
                end
            end
            ARB_START: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (tx_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ARB_WAIT;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    tx_start_d = 1'b0;
                    err_d      = 1'b1;
                    last_d     = owner;
`ifdef UART_ARB_LOCK_EN
                    lock_ok_d  = 1'b0;
`endif
                    state_d    = ARB_IDLE;
                end
            end
            ARB_WAIT: begin
                if (tx_done || (busy_q && !tx_busy)) begin
                    sent_d[owner] = 1'b1;
                    last_d        = owner;
`ifdef UART_ARB_LOCK_EN
                    lock_ok_d     = 1'b1;
`endif
                    state_d       = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
        arb_busy_d = (state_d != ARB_IDLE);
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ARB_IDLE;
            last_q    <= ID_W'(N_REQ - 1);
            owner     <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            ack       <= '0;
            sent      <= '0;
            err       <= 1'b0;
            arb_busy  <= 1'b0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_ok_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner     <= owner_d;
            tx_data   <= tx_data_d;
            tx_start  <= tx_start_d;
            ack       <= ack_d;
            sent      <= sent_d;
            err       <= err_d;
            arb_busy  <= arb_busy_d;
            tmo_q     <= tmo_d;
            busy_q    <= tx_busy;
`ifdef UART_ARB_LOCK_EN
            lock_ok_q <= lock_ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: transaction-level round-robin model,
// scripted/random UART TX responder, and a decoupled output monitor.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 8;

`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   lock_v;
    logic [N-1:0]   ack, sent;
    logic [1:0]     owner;
    logic           arb_busy, err, tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy, tx_done;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef UART_ARB_LOCK_EN
        .lock     (lock_v),
`endif
        .ack      (ack),
        .sent     (sent),
        .owner    (owner),
        .arb_busy (arb_busy),
        .err      (err),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done)
    );

    typedef struct { int id; logic [7:0] data; } grant_t;
    typedef struct { int id; bit is_err; } out_t;
    typedef struct { bit stall; int dly; int len; bit use_done; } plan_t;

    grant_t     sb_grant[$];
    out_t       sb_out[$];
    plan_t      plan_q[$];
    plan_t      plan_force[$];
    int         exp_ord[$];
    int         obs_ord[$];
    logic [7:0] req_mem[N][256];
    int         head[N];
    int         tail[N];
    int         total = 0;
    int         bad = 0;
    int         m_last = N - 1;
    bit         m_lock_ok = 1'b0;
    bit         tx_idle = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic finish_up();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic add_byte(input int id, input logic [7:0] b);
        req_mem[id][tail[id]] = b;
        tail[id]++;
    endtask

    function automatic plan_t rand_plan();
        plan_t p;
        p.stall    = ($urandom_range(0, 9) == 0);
        p.dly      = int'($urandom_range(0, TMO - 1));
        p.len      = int'($urandom_range(1, 10));
        p.use_done = 1'($urandom_range(0, 1));
        return p;
    endfunction

    // Reference model: replay all pending bytes through the arbitration rules.
    task automatic issue();
        int    pend[N];
        int    ptr[N];
        int    sel;
        int    c;
        plan_t p;
        grant_t g;
        out_t  o;
        for (int i = 0; i < N; i++) begin
            pend[i] = tail[i] - head[i];
            ptr[i]  = head[i];
        end
        for (int n = 0; n < 1024; n++) begin
            sel = -1;
            if (LOCK_EN && m_lock_ok && lock_v[2'(m_last)] && pend[m_last] > 0)
                sel = m_last;
            else
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (sel < 0 && pend[c] > 0) sel = c;
                end
            if (sel < 0) break;
            g.id   = sel;
            g.data = req_mem[sel][ptr[sel]];
            ptr[sel]++;
            pend[sel]--;
            if (plan_force.size() > 0) p = plan_force.pop_front();
            else p = rand_plan();
            o.id     = sel;
            o.is_err = p.stall;
            sb_grant.push_back(g);
            sb_out.push_back(o);
            plan_q.push_back(p);
            m_last    = sel;
            m_lock_ok = !p.stall;
        end
    endtask

    task automatic drain(input int budget);
        int  n;
        bit  empty;
        n = 0;
        forever begin
            empty = 1'b1;
            for (int i = 0; i < N; i++) if (head[i] != tail[i]) empty = 1'b0;
            if ((sb_grant.size() == 0 && sb_out.size() == 0 && tx_idle && !arb_busy && empty)
                || n >= budget) break;
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= budget) begin
            bad++;
            $display("FAIL drain: %0d grants and %0d outcomes still pending after %0d cycles",
                     sb_grant.size(), sb_out.size(), n);
            finish_up();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_order(input string nm);
        chk({nm, "_count"}, 32'(obs_ord.size()), 32'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size() && i < obs_ord.size(); i++)
            chk({nm, "_id"}, 32'(obs_ord[i]), 32'(exp_ord[i]));
        obs_ord.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        m_last    = N - 1;
        m_lock_ok = 1'b0;
    endtask

    // Requesters: pop a byte on ack, then present the next one (req drops when empty).
    initial begin
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        req      = '0;
        req_data = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (ack[i] && head[i] < tail[i]) head[i]++;
            #1;
            for (int i = 0; i < N; i++) begin
                req[i]            = (head[i] < tail[i]);
                req_data[8*i +: 8] = (head[i] < tail[i]) ? req_mem[i][head[i]] : 8'h00;
            end
        end
    end

    // UART TX responder following the per-transfer plan queue.
    initial begin
        plan_t p;
        int    n;
        tx_busy = 1'b0;
        tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start && !rst) begin
                tx_idle = 1'b0;
                if (plan_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL tx_start_unplanned: tx_start=1, want no transfer");
                    p = '{1'b1, 0, 0, 1'b0};
                end else begin
                    p = plan_q.pop_front();
                end
                if (p.stall) begin
                    tx_done = 1'b1;
                    @(negedge clk);
                    tx_done = 1'b0;
                    n = 0;
                    while (tx_start && n < 4 * TMO) begin
                        @(negedge clk);
                        n++;
                    end
                end else begin
                    repeat (p.dly) @(negedge clk);
                    tx_busy = 1'b1;
                    repeat (p.len) @(negedge clk);
                    if (p.use_done) begin
                        tx_done = 1'b1;
                        @(negedge clk);
                        tx_done = 1'b0;
                    end
                    tx_busy = 1'b0;
                end
                tx_idle = 1'b1;
            end
        end
    end

    // Monitor: pop expected grants/outcomes whenever the DUT pulses ack/sent/err.
    initial begin
        int         run;
        int         aid;
        logic [7:0] cur_data;
        grant_t     g;
        out_t       o;
        run      = 0;
        cur_data = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                run = 0;
            end else begin
                if (|ack || |sent || err)
                    chk("pulse_exclusive",
                        32'($onehot0(ack) && $onehot0(sent) &&
                            ((32'(|ack) + 32'(|sent) + 32'(err)) == 1)), 32'd1);
                if (|ack) begin
                    aid = 0;
                    for (int i = 0; i < N; i++) if (ack[i]) aid = i;
                    obs_ord.push_back(aid);
                    if (sb_grant.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ack_unexpected: ack=%b, want none", ack);
                    end else begin
                        g = sb_grant.pop_front();
                        chk("ack_vec", 32'(ack), 32'(1) << g.id);
                        chk("ack_tx_data", 32'(tx_data), 32'(g.data));
                        chk("ack_owner", 32'(owner), 32'(g.id));
                        chk("ack_tx_start", 32'(tx_start), 32'd1);
                        cur_data = g.data;
                    end
                end
                if (|sent || err) begin
                    if (sb_out.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL outcome_unexpected: sent=%b err=%b, want none", sent, err);
                    end else begin
                        o = sb_out.pop_front();
                        chk("outcome_is_err", 32'(err), 32'(o.is_err));
                        chk("outcome_owner", 32'(owner), 32'(o.id));
                        chk("outcome_tx_data", 32'(tx_data), 32'(cur_data));
                        if (|sent) chk("sent_vec", 32'(sent), 32'(1) << o.id);
                        if (err) chk("err_start_cycles", 32'(run), 32'(TMO));
                    end
                end
                run = tx_start ? run + 1 : 0;
            end
        end
    end

    initial begin
        #400000;
        bad++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_up();
    end

    // Directed scenarios followed by randomized rounds.
    initial begin
        int cnt;
        int nb;
        rst    = 1'b1;
        lock_v = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_sent", 32'(sent), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(arb_busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Single request: latency and start/busy handshake.
        plan_force.push_back('{1'b0, 1, 3, 1'b1});
        add_byte(0, 8'hA5);
        issue();
        @(negedge clk);
        chk("t1_ack", 32'(ack), 32'd1);
        chk("t1_tx_start", 32'(tx_start), 32'd1);
        chk("t1_tx_data", 32'(tx_data), 32'hA5);
        chk("t1_arb_busy", 32'(arb_busy), 32'd1);
        @(negedge clk);
        chk("t1_start_held", 32'(tx_start), 32'd1);
        @(negedge clk);
        chk("t1_start_drop", 32'(tx_start), 32'd0);
        drain(200);
        obs_ord.delete();

        // All four requesting from reset: 0,1,2,3,0.
        do_reset();
        add_byte(0, 8'hA0); add_byte(0, 8'hA4);
        add_byte(1, 8'hA1); add_byte(2, 8'hA2); add_byte(3, 8'hA3);
        for (int i = 0; i < 5; i++) plan_force.push_back('{1'b0, i, 2 + i, 1'(i % 2)});
        issue();
        drain(500);
        exp_ord = '{0, 1, 2, 3, 0};
        chk_order("t2_order");

        // last grant 0, req 0101: 2 before 0.
        add_byte(0, 8'h10); add_byte(2, 8'h12);
        issue();
        drain(500);
        exp_ord = '{2, 0};
        chk_order("t3_order");

        // Start timeout on requester 1, then requester 2 still served.
        plan_force.push_back('{1'b1, 0, 0, 1'b0});
        plan_force.push_back('{1'b0, 2, 3, 1'b0});
        add_byte(1, 8'h21); add_byte(2, 8'h22);
        issue();
        drain(500);
        exp_ord = '{1, 2};
        chk_order("t4_order");

        // Busy arrives on the very cycle the timeout expires: busy wins.
        plan_force.push_back('{1'b0, TMO - 1, 2, 1'b1});
        add_byte(3, 8'h33);
        issue();
        drain(500);
        exp_ord = '{3};
        chk_order("t4b_order");

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            lock_v = N'($urandom_range(0, (1 << N) - 1));
            nb = 0;
            for (int i = 0; i < N; i++) begin
                cnt = int'($urandom_range(0, 3));
                for (int b = 0; b < cnt; b++) add_byte(i, 8'($urandom_range(0, 255)));
                nb += cnt;
            end
            if (nb == 0) add_byte(int'($urandom_range(0, N - 1)), 8'($urandom_range(0, 255)));
            issue();
            drain(3000);
        end
        obs_ord.delete();

        // Reset during WAIT abandons the byte.
        lock_v = '0;
        plan_force.push_back('{1'b0, 0, 20, 1'b0});
        add_byte(1, 8'h3C);
        issue();
        cnt = 0;
        while (!(tx_busy && arb_busy && !tx_start) && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        chk("t5_reached_wait", 32'(cnt < 50), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ack", 32'(ack), 32'd0);
        chk("t5_sent", 32'(sent), 32'd0);
        chk("t5_err", 32'(err), 32'd0);
        chk("t5_tx_start", 32'(tx_start), 32'd0);
        chk("t5_arb_busy", 32'(arb_busy), 32'd0);
        chk("t5_owner", 32'(owner), 32'd0);
        chk("t5_tx_data", 32'(tx_data), 32'd0);
        rst = 1'b0;
        sb_out.delete();
        sb_grant.delete();
        m_last    = N - 1;
        m_lock_ok = 1'b0;
        cnt = 0;
        while (!tx_idle && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        obs_ord.delete();
        add_byte(1, 8'h5A);
        issue();
        drain(500);
        exp_ord = '{1};
        chk_order("t5_after_reset");

        // Lock on requester 0 keeps its frame together when enabled.
        do_reset();
        lock_v = N'(1);
        for (int i = 0; i < 4; i++) plan_force.push_back('{1'b0, 1, 2, 1'b1});
        add_byte(0, 8'hC0); add_byte(0, 8'hC1); add_byte(0, 8'hC2); add_byte(1, 8'hC3);
        issue();
        drain(500);
        if (LOCK_EN) exp_ord = '{0, 0, 0, 1};
        else exp_ord = '{0, 1, 0, 0};
        chk_order("t6_order");

        finish_up();
    end

endmodule
